// File: rtl/axi_byte_ser_pkg.sv
// rtl/axi_byte_ser_pkg.sv - shared constants and byte-select helper for the byte serializer
// Purpose: byte width constant and sel_byte(), which picks byte number idx of a word
//          (counted in emission order) for either byte order.
// Ports:   none (package).
package axi_byte_ser_pkg;

    localparam int BYTE_W     = 8;
    // Widest word sel_byte() accepts; callers zero-extend narrower words to this width.
    localparam int MAX_WORD_W = 256;

    // idx counts beats in emission order: 0 is the first byte on the wire.
    function automatic logic [BYTE_W-1:0] sel_byte(
        input logic [MAX_WORD_W-1:0] word,
        input int                    idx,
        input int                    bytes,
        input bit                    lsb_first
    );
        int                    pos;
        logic [MAX_WORD_W-1:0] shifted;
        pos     = lsb_first ? idx : (bytes - 1 - idx);
        shifted = word >> (pos * BYTE_W);
        return shifted[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// rtl/axi_stream_if.sv - plain AXI-Stream signal bundle
// Purpose: groups tdata/tvalid/tready/tlast for one stream of bytes*8 data bits.
// Ports:   none; signals tdata[bytes*8-1:0], tvalid, tready, tlast.
interface axi_stream_if #(
    parameter int bytes = 1
) ();
    logic [bytes*8-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
endinterface

// File: rtl/axi_stream_byte_serializer.sv
// rtl/axi_stream_byte_serializer.sv - BYTES-wide word to 1-byte AXI-Stream serializer
// Purpose: accepts one BYTES-byte word per s_ handshake and emits it as BYTES registered
//          byte beats on m_, back-to-back words with no idle cycle.
// Ports:
//   clk       in   1        clock, posedge
//   reset_n   in   1        asynchronous active-low reset
//   s_tdata   in   BYTES*8  input word
//   s_tvalid  in   1        input word valid
//   s_tready  out  1        word accepted this cycle (combinational from m_tready)
//   m_tdata   out  8        output byte (registered)
//   m_tvalid  out  1        output byte valid (registered)
//   m_tready  in   1        sink accepts byte
//   m_tlast   out  1        final byte of a word (registered)
//   word_cnt  out  32       words whose last byte was accepted, wraps
module axi_stream_byte_serializer
    import axi_byte_ser_pkg::*;
#(
    parameter int BYTES     = 5,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [BYTES*8-1:0]   s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [BYTE_W-1:0]    m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [31:0]          word_cnt
);

    localparam int              IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam bit              LSB      = (LSB_FIRST != 0);

    logic [BYTES*8-1:0] hold;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic               full;
    logic               at_last;
    logic               beat;
    logic               accept;

    assign at_last  = (idx == LAST_IDX);
    assign idx_nxt  = idx + IDX_W'(1);
    assign beat     = full & m_tready;
    // Taking a new word in the same cycle the last byte leaves is what removes the bubble.
    assign s_tready = !full | (m_tready & at_last);
    assign accept   = s_tvalid & s_tready;
    assign m_tvalid = full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold     <= '0;
            idx      <= '0;
            full     <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (beat && at_last) begin
                word_cnt <= word_cnt + 32'd1;
            end

            if (accept) begin
                // s_tdata is only sampled here, so garbage on an ignored word never lands.
                hold    <= s_tdata;
                idx     <= '0;
                full    <= 1'b1;
                m_tdata <= sel_byte(MAX_WORD_W'(s_tdata), 0, BYTES, LSB);
                m_tlast <= 1'b0;
            end else if (beat) begin
                if (at_last) begin
                    full    <= 1'b0;
                    m_tlast <= 1'b0;
                end else begin
                    // idx only advances below LAST_IDX, so unused codes are never reached.
                    idx     <= idx_nxt;
                    m_tdata <= sel_byte(MAX_WORD_W'(hold), int'(idx_nxt), BYTES, LSB);
                    m_tlast <= (idx_nxt == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_byte_serializer.sv
// tb/tb_axi_stream_byte_serializer.sv - scoreboard bench for axi_stream_byte_serializer
module tb_axi_stream_byte_serializer;

    localparam int BYTES = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    axi_stream_if #(.bytes(BYTES)) s_if ();
    axi_stream_if #(.bytes(1))     m_if ();
    axi_stream_if #(.bytes(BYTES)) s2_if ();
    axi_stream_if #(.bytes(1))     m2_if ();

    logic [31:0] word_cnt;
    logic [31:0] word_cnt2;

    axi_stream_byte_serializer #(.BYTES(BYTES), .LSB_FIRST(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tdata  (s_if.tdata),
        .s_tvalid (s_if.tvalid),
        .s_tready (s_if.tready),
        .m_tdata  (m_if.tdata),
        .m_tvalid (m_if.tvalid),
        .m_tready (m_if.tready),
        .m_tlast  (m_if.tlast),
        .word_cnt (word_cnt)
    );

    axi_stream_byte_serializer #(.BYTES(BYTES), .LSB_FIRST(0)) dut_msb (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tdata  (s2_if.tdata),
        .s_tvalid (s2_if.tvalid),
        .s_tready (s2_if.tready),
        .m_tdata  (m2_if.tdata),
        .m_tvalid (m2_if.tvalid),
        .m_tready (m2_if.tready),
        .m_tlast  (m2_if.tlast),
        .word_cnt (word_cnt2)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    bit         rand_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: byte i of the emission sequence, from plain shifts of the word.
    function automatic logic [7:0] model_byte(input logic [39:0] w, input int i, input bit lsb);
        int sh;
        sh = lsb ? i : (BYTES - 1 - i);
        return 8'(w >> (8 * sh));
    endfunction

    task automatic push_word(input logic [39:0] w);
        for (int i = 0; i < BYTES; i++) begin
            exp_q.push_back({(i == BYTES - 1), model_byte(w, i, 1'b1)});
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send_word(input logic [39:0] w, input int gap);
        bit hs;
        int t;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 'x;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_if.tdata  = w;
        s_if.tvalid = 1'b1;
        push_word(w);
        t = 0;
        forever begin
            @(negedge clk);
            hs = s_if.tready;
            @(posedge clk);
            #1;
            if (hs) break;
            t++;
            if (t > 200) begin
                chk("s_handshake_timeout", 0, 1);
                break;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tdata  = 'x;
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected bytes on every m_ handshake and checks AXI stability.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", m_if.tvalid, 1);
                    chk("stall_data", m_if.tdata, prev_data);
                    chk("stall_last", m_if.tlast, prev_last);
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", m_if.tdata, 9'h100);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte_data", m_if.tdata, e[7:0]);
                        chk("byte_last", m_if.tlast, e[8]);
                    end
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_data  = m_if.tdata;
                prev_last  = m_if.tlast;
            end
        end
    end

    // Random m_tready: high runs 1-8, low runs 1-6.
    initial begin
        bit cur;
        int run;
        cur = 1'b0;
        run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                if (run == 0) begin
                    cur = !cur;
                    run = cur ? $urandom_range(1, 8) : $urandom_range(1, 6);
                end
                m_if.tready = cur;
                run--;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] w;
        logic [7:0]  eb;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tlast   = 1'b0;
        s2_if.tvalid = 1'b0;
        s2_if.tdata  = '0;
        s2_if.tlast  = 1'b0;
        m_if.tready  = 1'b0;
        m2_if.tready = 1'b1;
        reset_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tlast", m_if.tlast, 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_word_cnt", word_cnt, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_s_tready", s_if.tready, 1);
        @(posedge clk);
        #1;

        // 1: single word, LSB first
        m_if.tready = 1'b1;
        send_word(40'h4142434445, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_data", m_if.tdata, 8'h45 - 8'(i));
            chk("t1_valid", m_if.tvalid, 1);
            chk("t1_last", m_if.tlast, (i == 4));
        end
        @(negedge clk);
        chk("t1_idle_valid", m_if.tvalid, 0);
        chk("t1_word_cnt", word_cnt, 1);
        @(posedge clk);
        #1;

        // 2: back-to-back words, s_tvalid held high
        s_if.tdata  = 40'h4142434445;
        s_if.tvalid = 1'b1;
        push_word(40'h4142434445);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("t2_ready_empty", s_if.tready, 1);
            end else begin
                eb = (i <= 5) ? 8'h45 - 8'(i - 1) : 8'h4A - 8'(i - 6);
                chk("t2_data", m_if.tdata, eb);
                chk("t2_valid", m_if.tvalid, 1);
                chk("t2_s_tready", s_if.tready, (i == 5 || i == 10));
            end
            @(posedge clk);
            #1;
            if (i == 0) begin
                s_if.tdata = 40'h464748494A;
                push_word(40'h464748494A);
            end
            if (i == 5) begin
                s_if.tvalid = 1'b0;
                s_if.tdata  = 'x;
            end
        end
        @(negedge clk);
        chk("t2_idle_valid", m_if.tvalid, 0);
        chk("t2_word_cnt", word_cnt, 3);
        @(posedge clk);
        #1;

        // 3: m_tready low for 4 clocks after byte 44
        send_word(40'h4142434445, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        m_if.tready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3_hold_data", m_if.tdata, 8'h43);
            chk("t3_hold_valid", m_if.tvalid, 1);
            chk("t3_s_tready", s_if.tready, 0);
        end
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_resume", m_if.tdata, 8'h43 - 8'(i));
        end
        @(negedge clk);
        chk("t3_word_cnt", word_cnt, 4);
        @(posedge clk);
        #1;

        // 4: MSB-first instance
        s2_if.tdata  = 40'h4B4C4D4F4E;
        s2_if.tvalid = 1'b1;
        @(negedge clk);
        chk("t4_s_tready", s2_if.tready, 1);
        @(posedge clk);
        #1;
        s2_if.tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_data", m2_if.tdata, model_byte(40'h4B4C4D4F4E, i, 1'b0));
            chk("t4_last", m2_if.tlast, (i == 4));
        end
        @(negedge clk);
        chk("t4_word_cnt", word_cnt2, 1);
        @(posedge clk);
        #1;

        // 5: asynchronous reset mid-word
        send_word(40'h5051525354, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_valid", m_if.tvalid, 0);
        chk("t5_last", m_if.tlast, 0);
        chk("t5_word_cnt", word_cnt, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_word(40'h5556575859, 0);
        wait_drain(50);
        chk("t5_word_cnt_after", word_cnt, 1);

        // 6: random words, gaps and back-pressure
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        rand_ready = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            w = {8'($urandom), $urandom};
            send_word(w, $urandom_range(0, 3));
        end
        wait_drain(400);
        chk("t6_word_cnt", word_cnt, 2000);
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
